// File: rtl/balls_overlay_pkg.sv
// Shared definitions for the ball overlay register block.
// Holds the register map offsets, field widths, AXI response codes,
// the per-ball shadow register struct and a byte-strobe merge helper.
package balls_overlay_pkg;

    localparam int ADDR_CTRL      = 'h000;
    localparam int ADDR_STATUS    = 'h004;
    localparam int ADDR_FRAME_CNT = 'h008;
    localparam int ADDR_BALL_EN   = 'h00C;

    localparam int BALL_BASE   = 'h010;
    localparam int BALL_STRIDE = 'h010;
    localparam int OFF_POS     = 'h0;
    localparam int OFF_RADIUS  = 'h4;
    localparam int OFF_RGB     = 'h8;

    // Widest fields the register map can carry; COORD_W/RAD_W truncate these.
    localparam int POS_FIELD_W = 12;
    localparam int RAD_FIELD_W = 32;
    localparam int RGB_W       = 24;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [POS_FIELD_W-1:0] y;
        logic [POS_FIELD_W-1:0] x;
        logic [RAD_FIELD_W-1:0] r;
        logic [RGB_W-1:0]       rgb;
    } ball_regs_t;

    function automatic int ball_addr(input int idx, input int off);
        return BALL_BASE + BALL_STRIDE * idx + off;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
        logic [31:0] v;
        v = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) v[k*8 +: 8] = new_v[k*8 +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/balls_overlay_axil_if.sv
// AXI4-Lite slave handshake for the ball overlay registers.
// Turns each accepted AW+W pair into a single-cycle wr_en_o strobe and
// each accepted AR into a same-cycle combinational read of rd_data_i.
// Ports: clk_i/rst_i (sync, active-high), AXI4-Lite channels, register
// port (wr_en_o/wr_addr_o/wr_data_o/wr_strb_o/wr_err_i,
// rd_addr_o/rd_data_i/rd_err_i).
module balls_overlay_axil_if
    import balls_overlay_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic [DATA_W/8-1:0] wr_strb_o,
    input  logic                wr_err_i,
    output logic [ADDR_W-1:0]   rd_addr_o,
    input  logic [DATA_W-1:0]   rd_data_i,
    input  logic                rd_err_i
);

    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_accept, rd_accept;

    // Ready is gated by reset so nothing is accepted in the reset cycle.
    assign wr_accept = awvalid_i & wvalid_i & ~bvalid_q & ~rst_i;
    assign rd_accept = arvalid_i & ~rvalid_q & ~rst_i;

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (wr_accept) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (bready_i) begin
            bvalid_d = 1'b0;
        end
        if (rd_accept) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
            rdata_d  = rd_err_i ? '0 : rd_data_i;
        end else if (rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign awready_o = wr_accept;
    assign wready_o  = wr_accept;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = rd_accept;
    assign rvalid_o  = rvalid_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;

    assign wr_en_o   = wr_accept;
    assign wr_addr_o = awaddr_i;
    assign wr_data_o = wdata_i;
    assign wr_strb_o = wstrb_i;
    assign rd_addr_o = araddr_i;

endmodule

// File: rtl/balls_overlay_regs.sv
// Double-buffered ball overlay register file.
// Software writes shadow registers over AXI4-Lite and requests a commit;
// the whole shadow set is copied to the active outputs on the next
// frame_start so the renderer never sees a half-updated frame.
// Ports: s00_axi_* AXI4-Lite slave (sync active-high reset), frame_start
// pulse in, packed active ball_x/ball_y/ball_r/ball_rgb/ball_en out,
// irq_commit pulse out.
module balls_overlay_regs
    import balls_overlay_pkg::*;
#(
    parameter int NUM_BALLS          = 16,
    parameter int COORD_W            = 11,
    parameter int RAD_W              = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic                            frame_start,
    output logic [NUM_BALLS*COORD_W-1:0]    ball_x,
    output logic [NUM_BALLS*COORD_W-1:0]    ball_y,
    output logic [NUM_BALLS*RAD_W-1:0]      ball_r,
    output logic [NUM_BALLS*24-1:0]         ball_rgb,
    output logic [NUM_BALLS-1:0]            ball_en,
    output logic                            irq_commit
);

    localparam int AW         = C_S_AXI_ADDR_WIDTH;
    localparam int ADDR_LIMIT = BALL_BASE + BALL_STRIDE * NUM_BALLS;
    localparam logic [POS_FIELD_W-1:0] X_MASK = 12'hFFF >> (POS_FIELD_W - COORD_W);
    localparam logic [RAD_FIELD_W-1:0] R_MASK = 32'hFFFF_FFFF >> (RAD_FIELD_W - RAD_W);

    logic          wr_en, wr_err, rd_err, copy, commit_wr;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [31:0]   wr_data, wr_old, wr_val, rd_data;
    logic [3:0]    wr_strb;

    ball_regs_t             shadow_q [NUM_BALLS];
    logic                   shadow_gen_q;
    logic [NUM_BALLS-1:0]   shadow_ben_q;
    logic                   pending_q, pending_d;
    logic [31:0]            fcnt_q;
    logic                   irq_q;
    logic [NUM_BALLS*COORD_W-1:0] ball_x_q, ball_y_q;
    logic [NUM_BALLS*RAD_W-1:0]   ball_r_q;
    logic [NUM_BALLS*24-1:0]      ball_rgb_q;
    logic [NUM_BALLS-1:0]         ball_en_q;

    balls_overlay_axil_if #(.ADDR_W(AW), .DATA_W(C_S_AXI_DATA_WIDTH)) u_axil (
        .clk_i     (s00_axi_aclk),
        .rst_i     (s00_axi_areset),
        .awaddr_i  (s00_axi_awaddr),
        .awvalid_i (s00_axi_awvalid),
        .awready_o (s00_axi_awready),
        .wdata_i   (s00_axi_wdata),
        .wstrb_i   (s00_axi_wstrb),
        .wvalid_i  (s00_axi_wvalid),
        .wready_o  (s00_axi_wready),
        .bresp_o   (s00_axi_bresp),
        .bvalid_o  (s00_axi_bvalid),
        .bready_i  (s00_axi_bready),
        .araddr_i  (s00_axi_araddr),
        .arvalid_i (s00_axi_arvalid),
        .arready_o (s00_axi_arready),
        .rdata_o   (s00_axi_rdata),
        .rresp_o   (s00_axi_rresp),
        .rvalid_o  (s00_axi_rvalid),
        .rready_i  (s00_axi_rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_err_i  (wr_err),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .rd_err_i  (rd_err)
    );

    function automatic logic hit(input logic [AW-1:0] a, input int off);
        return int'(a) == off;
    endfunction

    function automatic logic addr_err(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (int'(a) >= ADDR_LIMIT);
    endfunction

    // Shadow view of a register; also used as the base for strobed writes.
    function automatic logic [31:0] reg_read(input logic [AW-1:0] a);
        logic [31:0] v;
        v = '0;
        if (hit(a, ADDR_CTRL))      v[0] = shadow_gen_q;
        if (hit(a, ADDR_STATUS))    v = {16'h0, 8'(NUM_BALLS), 7'h0, pending_q};
        if (hit(a, ADDR_FRAME_CNT)) v = fcnt_q;
        if (hit(a, ADDR_BALL_EN)) begin
            for (int j = 0; j < NUM_BALLS; j++) begin
                if (j < 32) v[j[4:0]] = shadow_ben_q[j];
            end
        end
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (hit(a, ball_addr(i, OFF_POS)))    v = {4'h0, shadow_q[i].y, 4'h0, shadow_q[i].x};
            if (hit(a, ball_addr(i, OFF_RADIUS))) v = shadow_q[i].r;
            if (hit(a, ball_addr(i, OFF_RGB)))    v = {8'h0, shadow_q[i].rgb};
        end
        return v;
    endfunction

    always_comb begin
        wr_err  = addr_err(wr_addr);
        rd_err  = addr_err(rd_addr);
        rd_data = reg_read(rd_addr);
        wr_old  = reg_read(wr_addr);
        wr_val  = apply_wstrb(wr_old, wr_data, wr_strb);
        // CTRL bit1 always reads 0, so wr_val[1] is set only by a strobed 1.
        commit_wr = wr_en & ~wr_err & hit(wr_addr, ADDR_CTRL) & wr_val[1];
        copy      = frame_start & pending_q;
        // A commit landing with frame_start re-arms for the next frame.
        pending_d = commit_wr | (pending_q & ~frame_start);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_BALLS; i++) shadow_q[i] <= '0;
            shadow_gen_q <= 1'b0;
            shadow_ben_q <= '0;
            pending_q    <= 1'b0;
            fcnt_q       <= '0;
            irq_q        <= 1'b0;
            ball_x_q     <= '0;
            ball_y_q     <= '0;
            ball_r_q     <= '0;
            ball_rgb_q   <= '0;
            ball_en_q    <= '0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= copy;
            fcnt_q    <= fcnt_q + {31'h0, frame_start};
            // Copy reads shadow_q before this cycle's write lands.
            if (copy) begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    ball_x_q[i*COORD_W +: COORD_W] <= shadow_q[i].x[COORD_W-1:0];
                    ball_y_q[i*COORD_W +: COORD_W] <= shadow_q[i].y[COORD_W-1:0];
                    ball_r_q[i*RAD_W +: RAD_W]     <= shadow_q[i].r[RAD_W-1:0];
                    ball_rgb_q[i*24 +: 24]         <= shadow_q[i].rgb;
                end
                ball_en_q <= shadow_ben_q & {NUM_BALLS{shadow_gen_q}};
            end
            if (wr_en && !wr_err) begin
                if (hit(wr_addr, ADDR_CTRL)) shadow_gen_q <= wr_val[0];
                if (hit(wr_addr, ADDR_BALL_EN)) begin
                    for (int j = 0; j < NUM_BALLS; j++) begin
                        if (j < 32) shadow_ben_q[j] <= wr_val[j[4:0]];
                    end
                end
                for (int i = 0; i < NUM_BALLS; i++) begin
                    if (hit(wr_addr, ball_addr(i, OFF_POS))) begin
                        shadow_q[i].x <= wr_val[11:0] & X_MASK;
                        shadow_q[i].y <= wr_val[27:16] & X_MASK;
                    end
                    if (hit(wr_addr, ball_addr(i, OFF_RADIUS))) shadow_q[i].r <= wr_val & R_MASK;
                    if (hit(wr_addr, ball_addr(i, OFF_RGB)))    shadow_q[i].rgb <= wr_val[23:0];
                end
            end
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign ball_r     = ball_r_q;
    assign ball_rgb   = ball_rgb_q;
    assign ball_en    = ball_en_q;
    assign irq_commit = irq_q;

endmodule
